sevenseg_mux: RTL and testbench

SEVENSEG_MUX -- requirements
Module: sevenseg_mux

---
 rtl/sevenseg_pkg.sv | 14 +
 rtl/sevenseg_glyph.sv | 13 +
 rtl/sevenseg_mux.sv | 120 ++++++++++++
 tb/tb_sevenseg_mux.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed seven-segment driver.
package sevenseg_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  // Active-high {a,b,c,d,e,f,g} glyphs, indexed by hex nibble
  localparam logic [SEG_W-1:0] GLYPH_HI [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/sevenseg_glyph.sv
// Nibble to active-low segment pattern lookup (purely combinational).
module sevenseg_glyph
  import sevenseg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_n_c
);

  always_comb begin
    seg_n_c = ~GLYPH_HI[nibble];
  end

endmodule

// File: rtl/sevenseg_mux.sv
// Time-multiplexed seven-segment scanner with frame-synchronous buffer updates,
// anti-ghost blanking and optional leading-zero suppression.
module sevenseg_mux
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          LZ_BLANK     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank,
  output logic [SEG_W-1:0]        seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    update_pending
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]                cnt;
  logic [IDX_W-1:0]                idx;
  logic [NUM_DIGITS-1:0][3:0]      shadow_val;
  logic [NUM_DIGITS-1:0][3:0]      disp_val;
  logic [NUM_DIGITS-1:0]           shadow_dp;
  logic [NUM_DIGITS-1:0]           disp_dp;

  logic                            slot_end_c;
  logic                            frame_end_c;
  logic                            zero_run_c;
  logic [NUM_DIGITS-1:0]           lz_mask_c;
  logic [3:0]                      nibble_c;
  logic [SEG_W-1:0]                glyph_n_c;
  logic [SEG_W-1:0]                seg_c;
  logic                            dp_c;
  logic [NUM_DIGITS-1:0]           an_c;

  assign slot_end_c  = (cnt == CNT_LAST);
  assign frame_end_c = slot_end_c && (idx == IDX_LAST);
  assign nibble_c    = disp_val[idx];

  // A digit is dark when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    zero_run_c = 1'b1;
    lz_mask_c  = '0;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      zero_run_c   = zero_run_c && (disp_val[i] == 4'h0);
      lz_mask_c[i] = LZ_BLANK && zero_run_c;
    end
  end

  sevenseg_glyph u_glyph (
    .nibble  (nibble_c),
    .seg_n_c (glyph_n_c)
  );

  always_comb begin
    seg_c = glyph_n_c;
    dp_c  = ~disp_dp[idx];
    an_c  = '1;
    if (cnt >= CNT_BLANK) begin
      an_c[idx] = 1'b0;
    end
    if (lz_mask_c[idx]) begin
      seg_c = SEG_OFF;
    end
    if (blank) begin
      seg_c = SEG_OFF;
      dp_c  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      idx            <= '0;
      shadow_val     <= '0;
      shadow_dp      <= '0;
      disp_val       <= '0;
      disp_dp        <= '0;
      update_pending <= 1'b0;
      seg_n          <= SEG_OFF;
      dp_n           <= 1'b1;
      an_n           <= '1;
    end else begin
      cnt <= slot_end_c ? '0 : cnt + CNT_W'(1);
      if (slot_end_c) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      // A load landing on the frame boundary bypasses the shadow wait
      if (load && frame_end_c) begin
        disp_val       <= value;
        disp_dp        <= dp_in;
        update_pending <= 1'b0;
      end else if (load) begin
        update_pending <= 1'b1;
      end else if (frame_end_c && update_pending) begin
        disp_val       <= shadow_val;
        disp_dp        <= shadow_dp;
        update_pending <= 1'b0;
      end
      seg_n <= seg_c;
      dp_n  <= dp_c;
      an_n  <= an_c;
    end
  end

endmodule

// File: tb/tb_sevenseg_mux.sv
// Frame-level checks of sevenseg_mux (4 digits, 8-cycle slots, 2-cycle blank).
module tb_sevenseg_mux;

  typedef struct packed {
    logic [3:0][6:0] seg;
    logic [3:0][6:0] seg_lz;
    logic [3:0]      dp_n;
  } frame_t;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank;
    frame_t      exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank;
  logic [6:0]  seg_n, seg_n_lz;
  logic        dp_n, dp_n_lz;
  logic [3:0]  an_n, an_n_lz;
  logic        update_pending, update_pending_lz;

  int     total = 0;
  int     bad = 0;
  int     ecount = 0;
  bit     mon_busy = 1'b0;
  frame_t sb_q[$];
  vec_t   vecs [7];
  frame_t zero_f, x_f, z_f;

  sevenseg_mux #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1'b0)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .blank(blank),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .update_pending(update_pending)
  );

  sevenseg_mux #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .blank(blank),
    .seg_n(seg_n_lz), .dp_n(dp_n_lz), .an_n(an_n_lz), .update_pending(update_pending_lz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the bench's notion of where the scan should be
  always @(posedge clk) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (edge %0d)", name, got, want, ecount);
    end
  endtask

  task automatic wait_e(input int t);
    int guard;
    guard = 0;
    while (ecount != t) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 400) begin
        total++;
        bad++;
        $display("FAIL wait_edge: got %0d want %0d", ecount, t);
        break;
      end
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load  = 1'b0;
  endtask

  task automatic check_pending(input string name, input logic want);
    @(negedge clk);
    check(name, {14'h0, update_pending, update_pending_lz}, {14'h0, want, want});
  endtask

  // Scoreboard consumer: each queued frame is checked over 32 output cycles
  initial begin
    frame_t     ef;
    logic [3:0] exp_an;
    int         c, d;
    forever begin
      @(negedge clk);
      if (!rst && (ecount % 32 == 1) && sb_q.size() > 0) begin
        mon_busy = 1'b1;
        ef = sb_q.pop_front();
        for (int j = 0; j < 32; j++) begin
          if (j > 0) @(negedge clk);
          c = j % 8;
          d = j / 8;
          exp_an = (c >= 2) ? ~(4'b0001 << d) : 4'hF;
          check("scan_plain", {4'h0, an_n, seg_n, dp_n},
                {4'h0, exp_an, ef.seg[d], ef.dp_n[d]});
          check("scan_lz", {4'h0, an_n_lz, seg_n_lz, dp_n_lz},
                {4'h0, exp_an, ef.seg_lz[d], ef.dp_n[d]});
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    zero_f  = '{{7'h01, 7'h01, 7'h01, 7'h01}, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'hF};
    x_f     = '{{7'h01, 7'h12, 7'h01, 7'h01}, {7'h7F, 7'h12, 7'h01, 7'h01}, 4'hF};
    z_f     = '{{7'h4C, 7'h06, 7'h12, 7'h4F}, {7'h4C, 7'h06, 7'h12, 7'h4F}, 4'hE};
    vecs[0] = '{16'h1234, 4'h0, 1'b0,
                '{{7'h4F, 7'h12, 7'h06, 7'h4C}, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'hF}};
    vecs[1] = '{16'hABCD, 4'h5, 1'b0,
                '{{7'h08, 7'h60, 7'h31, 7'h42}, {7'h08, 7'h60, 7'h31, 7'h42}, 4'hA}};
    vecs[2] = '{16'h0050, 4'h0, 1'b0,
                '{{7'h01, 7'h01, 7'h24, 7'h01}, {7'h7F, 7'h7F, 7'h24, 7'h01}, 4'hF}};
    vecs[3] = '{16'h8888, 4'hF, 1'b1,
                '{{7'h7F, 7'h7F, 7'h7F, 7'h7F}, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF}};
    vecs[4] = '{16'h0000, 4'h8, 1'b0,
                '{{7'h01, 7'h01, 7'h01, 7'h01}, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'h7}};
    vecs[5] = '{16'hF0E7, 4'h0, 1'b0,
                '{{7'h38, 7'h01, 7'h30, 7'h0F}, {7'h38, 7'h01, 7'h30, 7'h0F}, 4'hF}};
    vecs[6] = '{16'h6908, 4'h2, 1'b0,
                '{{7'h20, 7'h04, 7'h01, 7'h00}, {7'h20, 7'h04, 7'h01, 7'h00}, 4'hD}};

    rst   = 1'b1;
    value = 16'h0;
    dp_in = 4'h0;
    load  = 1'b0;
    blank = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_plain", {3'h0, an_n, seg_n, dp_n, update_pending}, {3'h0, 4'hF, 7'h7F, 1'b1, 1'b0});
    check("reset_lz", {3'h0, an_n_lz, seg_n_lz, dp_n_lz, update_pending_lz}, {3'h0, 4'hF, 7'h7F, 1'b1, 1'b0});
    sb_q.push_back(zero_f);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Frame i shows vector i-1 while vector i is loaded mid-frame
    for (int i = 0; i < 7; i++) begin
      wait_e(32 * i);
      if (i > 0) blank = vecs[i-1].blank;
      wait_e(32 * i + 5);
      sb_q.push_back(vecs[i].exp);
      pulse_load(vecs[i].value, vecs[i].dp);
      check_pending("pending_set", 1'b1);
      wait_e(32 * i + 31);
      check_pending("pending_hold", 1'b1);
      wait_e(32 * i + 32);
      check_pending("pending_clear", 1'b0);
    end

    // Load on the exact frame-boundary cycle
    wait_e(32 * 7);
    blank = vecs[6].blank;
    wait_e(32 * 7 + 31);
    sb_q.push_back(x_f);
    pulse_load(16'h0200, 4'h0);
    @(negedge clk);
    check("boundary_pending", {14'h0, update_pending, update_pending_lz}, 16'h0);

    // Two loads in one frame: the second one wins
    wait_e(32 * 8 + 5);
    pulse_load(16'h1111, 4'h3);
    check_pending("double_first", 1'b1);
    wait_e(32 * 8 + 10);
    sb_q.push_back(z_f);
    pulse_load(16'h4321, 4'h1);
    check_pending("double_second", 1'b1);
    wait_e(32 * 8 + 31);
    check_pending("double_hold", 1'b1);
    wait_e(32 * 8 + 32);
    check_pending("double_clear", 1'b0);

    // Reset mid-slot with an update pending discards it
    wait_e(32 * 10 + 5);
    pulse_load(16'hFFFF, 4'hF);
    check_pending("rst_pending_set", 1'b1);
    wait_e(32 * 10 + 12);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_plain", {3'h0, an_n, seg_n, dp_n, update_pending}, {3'h0, 4'hF, 7'h7F, 1'b1, 1'b0});
    check("midrst_lz", {3'h0, an_n_lz, seg_n_lz, dp_n_lz, update_pending_lz}, {3'h0, 4'hF, 7'h7F, 1'b1, 1'b0});
    sb_q.push_back(zero_f);
    sb_q.push_back(zero_f);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_e(31);
    check_pending("post_rst_pending", 1'b0);
    wait_e(66);

    for (int g = 0; g < 100 && (mon_busy || sb_q.size() > 0); g++) begin
      @(posedge clk);
    end
    if (mon_busy || sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d frames left want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
